// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types and constants used by the writeback arbiter
//
// Provides the long-latency result record, the arbiter FIFO depth and starvation
// limit defaults, and the arbiter state encoding.

package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam int WB_ARB_DEPTH        = 4;
    localparam int WB_ARB_STARVE_LIMIT = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } lat_result_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUEUED  = 2'd1,
        STARVED = 2'd2
    } wb_arb_state_e;

endpackage

// File: rtl/wb_lat_fifo.sv
// rtl/wb_lat_fifo.sv - synchronous FIFO for long-latency writeback results
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_rd/data  write an entry (ignored when full)
//   pop                 remove the head entry (ignored when empty)
//   full, empty, last   occupancy flags (last: exactly one entry held)
//   head_rd/head_data   oldest entry
//   entry_rd            every slot's destination register, slot i at [i*AW +: AW]
//   entry_valid         per-slot occupancy, used to build the pending mask

module wb_lat_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [AW-1:0]       push_rd,
    input  logic [DW-1:0]       push_data,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic                last,
    output logic [AW-1:0]       head_rd,
    output logic [DW-1:0]       head_data,
    output logic [DEPTH*AW-1:0] entry_rd,
    output logic [DEPTH-1:0]    entry_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    rd_mem   [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign last      = (count == (PW+1)'(1));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign entry_valid = valid;

    always_comb begin
        entry_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i*AW +: AW] = rd_mem[i];
        end
    end

    // Push is refused when full, so a simultaneous push and pop never target
    // the same slot; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                rd_mem[wr_ptr]   <= push_rd;
                data_mem[wr_ptr] <= push_data;
                valid[wr_ptr]    <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline and long-latency results onto the regfile write port
//
// Optional feature macro: WB_ARB_BYPASS_EN (same-cycle write of a long-latency
// result when the FIFO is empty and the pipeline is not writing).
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_stall                      pipeline stall, suppresses the pipeline write
//   i_pipe_we/rd/data            in-order pipeline result
//   i_lat_valid/rd/data          long-latency result, accepted when o_lat_ready
//   o_lat_ready                  FIFO can accept
//   o_rf_we/waddr/wdata          regfile write port (combinational)
//   o_pending_mask               bit r set while a queued entry targets r
//   o_stall_req                  starvation stall request

module wb_write_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH        = WB_ARB_DEPTH,
    parameter int DATA_WIDTH   = XLEN,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = WB_ARB_STARVE_LIMIT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_stall,
    input  logic                        i_pipe_we,
    input  logic [$clog2(NUM_REGS)-1:0] i_pipe_rd,
    input  logic [DATA_WIDTH-1:0]       i_pipe_data,
    input  logic                        i_lat_valid,
    output logic                        o_lat_ready,
    input  logic [$clog2(NUM_REGS)-1:0] i_lat_rd,
    input  logic [DATA_WIDTH-1:0]       i_lat_data,
    output logic                        o_rf_we,
    output logic [$clog2(NUM_REGS)-1:0] o_rf_waddr,
    output logic [DATA_WIDTH-1:0]       o_rf_wdata,
    output logic [NUM_REGS-1:0]         o_pending_mask,
    output logic                        o_stall_req
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_last;
    logic [AW-1:0]          head_rd;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [DEPTH*AW-1:0]    entry_rd;
    logic [DEPTH-1:0]       entry_valid;

    logic                   pipe_commit;
    logic                   lat_accept;
    logic                   drain;
    logic                   bypass;
    logic                   enqueue;

    wb_arb_state_e          state;
    logic [SW-1:0]          starve_cnt;
    logic                   stall_q;

    // Nothing is written while reset is held, even if the pipeline asks.
    assign pipe_commit = ~i_rst & i_pipe_we & ~i_stall & (i_pipe_rd != '0);
    assign o_lat_ready = ~i_rst & ~fifo_full;
    assign lat_accept  = i_lat_valid & o_lat_ready;
    // A stall only blocks the pipeline's own write, so it opens a drain slot.
    assign drain       = ~i_rst & ~pipe_commit & ~fifo_empty;

`ifdef WB_ARB_BYPASS_EN
    assign bypass = ~pipe_commit & fifo_empty & lat_accept & (i_lat_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // x0 results complete the handshake but are dropped here.
    assign enqueue = lat_accept & (i_lat_rd != '0) & ~bypass;

    wb_lat_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DATA_WIDTH)
    ) u_fifo (
        .clk         (i_clk),
        .rst         (i_rst),
        .push        (enqueue),
        .push_rd     (i_lat_rd),
        .push_data   (i_lat_data),
        .pop         (drain),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .last        (fifo_last),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    always_comb begin
        o_rf_we    = 1'b0;
        o_rf_waddr = '0;
        o_rf_wdata = '0;
        if (pipe_commit) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = i_pipe_rd;
            o_rf_wdata = i_pipe_data;
        end else if (drain) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = head_rd;
            o_rf_wdata = head_data;
        end else if (bypass) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = i_lat_rd;
            o_rf_wdata = i_lat_data;
        end
    end

    always_comb begin
        o_pending_mask = '0;
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_valid[i]) begin
                    o_pending_mask[entry_rd[i*AW +: AW]] = 1'b1;
                end
            end
        end
    end

    // The registered request is masked during reset so it reads low in the
    // reset cycle itself, not only after it.
    assign o_stall_req = stall_q & ~i_rst;

    // starve_cnt holds the number of consecutive blocked cycles so far; the
    // transition to STARVED fires on the cycle that makes it STARVE_LIMIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (drain || fifo_empty) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enqueue) begin
                        state <= QUEUED;
                    end
                end
                QUEUED: begin
                    if (drain) begin
                        if (fifo_last && !enqueue) begin
                            state <= IDLE;
                        end
                    end else if (starve_cnt >= SW'(STARVE_LIMIT - 1)) begin
                        state   <= STARVED;
                        stall_q <= 1'b1;
                    end
                end
                STARVED: begin
                    if (drain) begin
                        stall_q <= 1'b0;
                        state   <= (fifo_last && !enqueue) ? IDLE : QUEUED;
                    end
                end
                default: begin
                    state   <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Producer side of the register-file write port.
- Merges two result sources onto the single regfile write port (enable/address/data):
  - in-order pipeline results arriving from the MA→WB boundary;
  - out-of-order long-latency results (divider, AMO) arriving via a valid/ready handshake.
- Long-latency results are buffered in a small FIFO and drained into free write slots.
- A starvation guard requests a pipeline stall so that queued results cannot wait forever.

Parameters:
- DEPTH, 4: long-latency FIFO entries (power of two, ≥2).
- DATA_WIDTH, 32: register width.
- NUM_REGS, 32: architectural registers; address width is $clog2(NUM_REGS).
- STARVE_LIMIT, 8: consecutive blocked cycles before a stall is requested.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_stall  in  1  pipeline stall; suppresses the pipeline write this cycle.
- i_pipe_we  in  1  pipeline result wants to write.
- i_pipe_rd  in  $clog2(NUM_REGS)  pipeline destination register.
- i_pipe_data  in  DATA_WIDTH  pipeline result.
- i_lat_valid  in  1  long-latency result valid.
- o_lat_ready  out  1  FIFO can accept.
- i_lat_rd  in  $clog2(NUM_REGS)  long-latency destination register.
- i_lat_data  in  DATA_WIDTH  long-latency result.
- o_rf_we  out  1  regfile write enable.
- o_rf_waddr  out  $clog2(NUM_REGS)  regfile write address.
- o_rf_wdata  out  DATA_WIDTH  regfile write data.
- o_pending_mask  out  NUM_REGS  bit r set while any queued entry targets register r.
- o_stall_req  out  1  starvation stall request to pipeline control.

Behaviour:
- Clocking and reset:
  - Single clock domain, i_clk; reset i_rst is synchronous, active-high.
  - During and after reset: FIFO empty; o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0; o_pending_mask=0; o_stall_req=0; starve counter=0.
  - o_lat_ready=0 while i_rst=1, and 1 in the first cycle after reset.
  - Reset mid-operation discards all queued entries; no write is emitted in the reset cycle.
- Write outputs are combinational from the current inputs and FIFO head (zero added latency on the pipeline path).
- Pipeline slot:
  - pipe_commit = i_pipe_we & ~i_stall & (i_pipe_rd≠0).
  - When pipe_commit=1, the pipeline always wins the write port: o_rf_we=1, o_rf_waddr=i_pipe_rd, o_rf_wdata=i_pipe_data.
- Drain:
  - If pipe_commit=0 and the FIFO is non-empty, the head is written and popped in that cycle.
  - i_stall alone does not block drain.
- Enqueue:
  - Handshake on i_lat_valid & o_lat_ready at the rising edge; o_lat_ready = ~full.
  - Results with i_lat_rd=0 are accepted (ready honoured) but never enqueued.
- Simultaneous push and pop when full:
  - o_lat_ready remains 0; a full FIFO does not accept in the same cycle it pops.
  - Pointers wrap modulo DEPTH; occupancy counter width is $clog2(DEPTH)+1.
- Pending mask:
  - Combinational OR of the one-hot decode of rd over all valid FIFO entries.
  - The bit clears in the cycle after the last matching entry drains.
- Ordering:
  - Issue logic must not issue a younger writer to any rd whose o_pending_mask bit is set.
  - The arbiter does not resolve WAW hazards; the bench asserts this constraint.
- Starvation guard:
  - The counter increments each cycle the FIFO is non-empty and the head is not drained; it resets on any drain or when the FIFO is empty.
  - When the count reaches STARVE_LIMIT, o_stall_req is registered high the next cycle and held until the head drains.
  - It drops in the cycle after that drain.
- FSM states: IDLE (empty), QUEUED (non-empty, draining opportunistically), STARVED (o_stall_req=1).
  - IDLE→QUEUED on enqueue.
  - QUEUED→STARVED when the counter reaches STARVE_LIMIT.
  - STARVED→QUEUED or IDLE on drain.
  - Any state→IDLE on reset.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, pipe_commit=0 and an accepted i_lat_rd≠0, the result is written to the regfile in the same cycle; it is not enqueued and the pending-mask bit is never set.
- Undefined: every long-latency result goes through the FIFO, giving a minimum of 1 cycle from accept to write.

Decomposition:
- Shared package riscv_pkg gains:
  - lat_result_t (rd, data);
  - WB_ARB_DEPTH and WB_ARB_STARVE_LIMIT constants.
- Sub-module wb_lat_fifo (synchronous FIFO with per-entry valid bits exposed for mask generation).
- Arbitration, FSM and mask logic stay in the top module.

Test Plan:
- Reset mid-operation: enqueue rd=5 then assert i_rst → o_rf_we=0, o_pending_mask=0, o_lat_ready=0 in the reset cycle; head never written.
- Priority: i_pipe_we=1 (rd=3, data=0x11), FIFO head rd=7 → cycle writes rd=3/0x11; next idle cycle writes rd=7; mask bit 7 clears the cycle after.
- Full and backpressure: DEPTH=4, push 4 results with continuous pipeline writes → o_lat_ready=0; fifth push stalls until the first drain.
- x0 filtering: i_lat_rd=0 and i_pipe_rd=0 → no o_rf_we, mask unchanged, ready honoured.
- Starvation: head blocked 8 cycles → o_stall_req=1 on cycle 9; drive i_stall=1 → head drains; o_stall_req=0 the next cycle.
- With WB_ARB_BYPASS_EN: empty FIFO, idle pipeline, push rd=9/0xAB → o_rf_we same cycle with rd=9/0xAB, mask stays 0.
- Without WB_ARB_BYPASS_EN: same stimulus → write one cycle later.
